rsd_to_twos_serial: RTL and testbench



---
 rtl/msdf_pkg.sv | 26 ++
 rtl/rsd_to_twos_serial_otf_step.sv | 37 +++
 rtl/rsd_to_twos_serial.sv | 120 ++++++++++++
 tb/tb_rsd_to_twos_serial.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF redundant-to-two's-complement conversion blocks.
package msdf_pkg;

  function automatic int clog2(input int value);
    int n;
    n = 0;
    for (int v = value - 1; v > 0; v = v >> 1) n++;
    return n;
  endfunction

  // Default configuration: radix-2 online adder with 15-digit operands.
  localparam int RADIX_DEF = 2;
  localparam int WIDTH_DEF = 15;
  localparam int K         = clog2(RADIX_DEF);
  localparam int D         = K + 1;
  localparam int BW        = K * (WIDTH_DEF + 1) + 1;

  localparam logic [D-1:0] DIGIT_ILLEGAL = {1'b1, {K{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

endpackage

// File: rtl/rsd_to_twos_serial_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q/QM pair without carries.
module otf_step
  import msdf_pkg::*;
#(
  parameter  int RADIX = 2,
  parameter  int RES_W = 17,
  localparam int LOG_R = clog2(RADIX),
  localparam int DIG_W = LOG_R + 1
) (
  input  logic [RES_W-1:0] q,
  input  logic [RES_W-1:0] qm,
  input  logic [DIG_W-1:0] d,
  output logic [RES_W-1:0] q_next,
  output logic [RES_W-1:0] qm_next,
  output logic             illegal
);

  logic [DIG_W-1:0] d_eff;
  logic [LOG_R-1:0] low_q;
  logic [LOG_R-1:0] low_qm;
  logic             neg;
  logic             pos;

  always_comb begin
    illegal = d[DIG_W-1] & ~(|d[LOG_R-1:0]);
    d_eff   = illegal ? '0 : d;
    neg     = d_eff[DIG_W-1];
    pos     = ~neg & (|d_eff[LOG_R-1:0]);
    // RADIX+d and RADIX-1+d reduce to the low K bits of d and d-1 respectively.
    low_q   = d_eff[LOG_R-1:0];
    low_qm  = d_eff[LOG_R-1:0] - LOG_R'(1);
    // The constant shift is pure wiring: high part shifted up, low field filled in.
    q_next  = ((neg ? qm : q) << LOG_R) | RES_W'(low_q);
    qm_next = ((pos ? q : qm) << LOG_R) | RES_W'(low_qm);
  end

endmodule

// File: rtl/rsd_to_twos_serial.sv
// Serial MSD-first converter from a redundant signed-digit sum word to two's complement.
// IDLE: wait for a word | CONV: one digit per cycle, MSD first | DONE: hold result until taken
module rsd_to_twos_serial
  import msdf_pkg::*;
#(
  parameter  int RADIX = 2,
  parameter  int WIDTH = 15,
  localparam int LOG_R = clog2(RADIX),
  localparam int DIG_W = LOG_R + 1,
  localparam int ND    = WIDTH + 1,
  localparam int NI    = DIG_W * ND,
  localparam int RES_W = LOG_R * ND + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NI-1:0]    s_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             err
);

  localparam int CNT_W = (clog2(ND) < 1) ? 1 : clog2(ND);

  state_t           state;
  state_t           state_nxt;
  logic [NI-1:0]    sreg;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] q;
  logic [RES_W-1:0] qm;
  logic [RES_W-1:0] q_step;
  logic [RES_W-1:0] qm_step;
  logic [DIG_W-1:0] digit;
  logic             illegal;
  logic             accept;
  logic             last_digit;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             err_r;
  logic [RES_W-1:0] result_r;

  // Word is shifted left each step, so the current digit always sits at the top.
  assign digit = sreg[NI-1 -: DIG_W];

  otf_step #(
    .RADIX (RADIX),
    .RES_W (RES_W)
  ) u_otf_step (
    .q       (q),
    .qm      (qm),
    .d       (digit),
    .q_next  (q_step),
    .qm_next (qm_step),
    .illegal (illegal)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_digit = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (cnt == '0) begin
          last_digit = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      err_r       <= 1'b0;
      q           <= '0;
      qm          <= '1;
      cnt         <= '0;
      sreg        <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_r  <= (state_nxt == IDLE);
      out_valid_r <= (state_nxt == DONE);
      if (accept) begin
        sreg  <= s_in;
        q     <= '0;
        qm    <= '1;
        cnt   <= CNT_W'(ND - 1);
        err_r <= 1'b0;
      end else if (state == CONV) begin
        q     <= q_step;
        qm    <= qm_step;
        sreg  <= sreg << DIG_W;
        err_r <= err_r | illegal;
        if (last_digit) result_r <= q_step;
        else            cnt      <= cnt - CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign err       = err_r;

endmodule

// File: tb/tb_rsd_to_twos_serial.sv
// Directed bench for rsd_to_twos_serial: a radix-4 and a radix-2 instance share clock and reset.
module tb_rsd_to_twos_serial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        iv4 = 1'b0, or4 = 1'b1, ir4, ov4, err4;
  logic [8:0]  s4 = '0;
  logic [6:0]  res4;

  logic        iv2 = 1'b0, or2 = 1'b1, ir2, ov2, err2;
  logic [31:0] s2 = '0;
  logic [16:0] res2;

  int vectors = 0;
  int misc    = 0;

  always #5 clock = ~clock;

  rsd_to_twos_serial #(.RADIX(4), .WIDTH(2)) u_r4 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4), .s_in(s4),
    .out_valid(ov4), .out_ready(or4), .result(res4), .err(err4)
  );

  rsd_to_twos_serial #(.RADIX(2), .WIDTH(15)) u_r2 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2), .s_in(s2),
    .out_valid(ov2), .out_ready(or2), .result(res2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      misc++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one word to the radix-4 instance; returns edges from accept to out_valid seen.
  task automatic send4(input logic [8:0] w, output int lat);
    @(negedge clock);
    s4  = w;
    iv4 = 1'b1;
    lat = 0;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    iv4 = 1'b0;
    while (!ov4 && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
  endtask

  initial begin
    int lat;
    int cyc;
    int t1;
    int t2;
    int seen;
    int pulses;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", ir4, 1);
    chk("rst_out_valid", ov4, 0);
    chk("rst_result", res4, 0);
    chk("rst_err", err4, 0);
    chk("rst_r2_in_ready", ir2, 1);
    reset_n = 1'b1;

    // [1,-1,2] -> 14
    send4(9'b001_111_010, lat);
    chk("w1_out_valid", ov4, 1);
    chk("w1_latency", lat, 4);
    chk("w1_result", res4, 7'b0001110);
    chk("w1_err", err4, 0);
    chk("w1_in_ready", ir4, 0);

    // [-1,0,-3] -> -19
    send4(9'b111_000_101, lat);
    chk("w2_out_valid", ov4, 1);
    chk("w2_result", res4, 7'b1101101);
    chk("w2_err", err4, 0);

    // [1,-4,0] -> illegal middle digit read as 0: 16 with err
    send4(9'b001_100_000, lat);
    chk("w3_out_valid", ov4, 1);
    chk("w3_result", res4, 7'd16);
    chk("w3_err", err4, 1);

    // [0,0,1] -> 1, err cleared
    send4(9'b000_000_001, lat);
    chk("w4_result", res4, 7'd1);
    chk("w4_err", err4, 0);

    // Radix-2 back-to-back: all -1 then all +1, out_ready held high
    @(negedge clock);
    s2  = 32'hFFFF_FFFF;
    iv2 = 1'b1;
    cyc = 0;
    t1  = 0;
    t2  = 0;
    seen = 0;
    while (seen < 2 && cyc < 80) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (ov2) begin
        seen++;
        if (seen == 1) begin
          t1 = cyc;
          chk("r2_neg_result", res2, 17'h10001);
          chk("r2_neg_err", err2, 0);
          s2 = 32'h5555_5555;
        end else begin
          t2 = cyc;
          chk("r2_pos_result", res2, 17'h0FFFF);
          iv2 = 1'b0;
        end
      end
    end
    iv2 = 1'b0;
    chk("r2_words_seen", seen, 2);
    chk("r2_latency", t1, 17);
    chk("r2_interval", t2 - t1, 18);

    // Stall in DONE for 10 cycles with a stray in_valid pulse
    or4 = 1'b0;
    send4(9'b000_000_001, lat);
    chk("st_out_valid", ov4, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        s4  = 9'h1FF;
        iv4 = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      iv4 = 1'b0;
      chk("st_hold_valid", ov4, 1);
      chk("st_hold_result", res4, 7'd1);
      chk("st_hold_in_ready", ir4, 0);
    end
    or4 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rel_in_ready", ir4, 1);
    chk("rel_out_valid", ov4, 0);
    chk("rel_result_held", res4, 7'd1);

    // Reset during CONV aborts the word
    s4  = 9'b001_111_010;
    iv4 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iv4 = 1'b0;
    chk("ab_in_ready_conv", ir4, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("ab_in_ready", ir4, 1);
    chk("ab_out_valid", ov4, 0);
    chk("ab_result", res4, 0);
    chk("ab_err", err4, 0);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (ov4) pulses++;
    end
    chk("ab_no_out_valid", pulses, 0);

    send4(9'b111_000_101, lat);
    chk("ab_fresh_valid", ov4, 1);
    chk("ab_fresh_latency", lat, 4);
    chk("ab_fresh_result", res4, 7'b1101101);
    chk("ab_fresh_err", err4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
